// File: rtl/heap_sort_node_kary.sv
// K-ary heapsort level node: sentinel fill, one-cycle sift-down swap with bypass.
// Ports: clk/rstn, init/max_mode/busy, um_* parent write, cm_* child mem, pl_* up, nl_* down.
module heap_sort_node_kary #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FANOUT     = 4,
  parameter int LEVEL      = 1,
  localparam int BW        = $clog2(FANOUT)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         init,
  input  logic                         max_mode,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        um_out,
  output logic [ADDR_WIDTH-1:0]        um_addr,
  output logic                         um_we,
  input  logic [FANOUT*DATA_WIDTH-1:0] cm_in,
  output logic [DATA_WIDTH-1:0]        cm_out,
  output logic [ADDR_WIDTH-1:0]        cm_addr,
  output logic [FANOUT-1:0]            cm_we,
  input  logic                         pl_update_in,
  input  logic [ADDR_WIDTH-1:0]        pl_addr_in,
  input  logic [BW-1:0]                pl_branch_in,
  input  logic [DATA_WIDTH-1:0]        pl_in,
  output logic [DATA_WIDTH-1:0]        pl_out,
  output logic                         pl_update_out,
  output logic [ADDR_WIDTH-1:0]        pl_addr_out,
  output logic [BW-1:0]                pl_branch_out,
  input  logic                         nl_update_in,
  input  logic [ADDR_WIDTH-1:0]        nl_addr_in,
  input  logic [BW-1:0]                nl_branch_in,
  input  logic [DATA_WIDTH-1:0]        nl_in,
  output logic [DATA_WIDTH-1:0]        nl_out,
  output logic                         nl_update_out,
  output logic [ADDR_WIDTH-1:0]        nl_addr_out,
  output logic [BW-1:0]                nl_branch_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam int NWORDS = FANOUT ** LEVEL;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NWORDS - 1);

  state_t state, state_nx;

  logic                  mode_r;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] caddr;
  logic [ADDR_WIDTH-1:0] caddr_r;
  logic [DATA_WIDTH-1:0] p_r;
  logic [DATA_WIDTH-1:0] n_r;
  logic [DATA_WIDTH-1:0] pl_q;
  logic [DATA_WIDTH-1:0] nl_q;
  logic [DATA_WIDTH-1:0] sent;
  logic [DATA_WIDTH-1:0] best;
  logic [DATA_WIDTH-1:0] c [FANOUT];
  logic [BW-1:0]         w;
  logic                  hit;
  logic                  swap;

  // a strictly better than b; same-type sentinels and equal keys tie
  function automatic logic better(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  mx
  );
    logic a_lo, a_hi, b_lo, b_hi, r;
    a_lo = (a[DATA_WIDTH-1 -: 2] == 2'b01);
    a_hi = (a[DATA_WIDTH-1 -: 2] == 2'b11);
    b_lo = (b[DATA_WIDTH-1 -: 2] == 2'b01);
    b_hi = (b[DATA_WIDTH-1 -: 2] == 2'b11);
    if (!mx) begin
      if (a_lo)      r = !b_lo;
      else if (a_hi) r = 1'b0;
      else if (b_lo) r = 1'b0;
      else if (b_hi) r = 1'b1;
      else r = a[KEY_WIDTH-1:0] < b[KEY_WIDTH-1:0];
    end else begin
      if (a_hi)      r = !b_hi;
      else if (a_lo) r = 1'b0;
      else if (b_hi) r = 1'b0;
      else if (b_lo) r = 1'b1;
      else r = a[KEY_WIDTH-1:0] > b[KEY_WIDTH-1:0];
    end
    return r;
  endfunction

  // branch < FANOUT, so concatenation equals addr*FANOUT+branch
  assign caddr = {pl_addr_in[ADDR_WIDTH-BW-1:0], pl_branch_in};
  assign sent  = {mode_r, 1'b1, {(DATA_WIDTH-2){1'b0}}};
  assign hit   = nl_update_in && (nl_addr_in == caddr_r);

  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      c[i] = cm_in[i*DATA_WIDTH +: DATA_WIDTH];
      if (hit && (nl_branch_in == BW'(i)))
        c[i] = nl_in;
    end
    w    = '0;
    best = c[0];
    // strict compare keeps the lowest index on ties
    for (int i = 1; i < FANOUT; i++) begin
      if (better(c[i], best, mode_r)) begin
        w    = BW'(i);
        best = c[i];
      end
    end
    swap = better(best, p_r, mode_r);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    cm_we         = '0;
    cm_addr       = caddr;
    pl_out        = pl_q;
    nl_out        = nl_q;
    pl_update_out = 1'b0;
    nl_update_out = 1'b0;
    nl_branch_out = '0;
    unique case (state)
      IDLE: begin
        if (init)              state_nx = INIT;
        else if (pl_update_in) state_nx = SWAP;
      end
      INIT: begin
        busy          = 1'b1;
        cm_we         = '1;
        cm_addr       = cnt;
        nl_out        = sent;
        nl_update_out = 1'b1;
        if (cnt == LAST) state_nx = IDLE;
      end
      SWAP: begin
        cm_addr       = caddr_r;
        nl_update_out = 1'b1;
        if (swap) begin
          pl_out        = best;
          nl_out        = p_r;
          pl_update_out = 1'b1;
          cm_we         = FANOUT'(1) << w;
          nl_branch_out = w;
        end else begin
          pl_out = p_r;
          nl_out = n_r;
        end
        state_nx = pl_update_in ? SWAP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r        <= 1'b0;
      cnt           <= '0;
      caddr_r       <= '0;
      p_r           <= '0;
      n_r           <= '0;
      pl_q          <= '0;
      nl_q          <= '0;
      pl_addr_out   <= '0;
      pl_branch_out <= '0;
    end else begin
      caddr_r       <= caddr;
      pl_addr_out   <= pl_addr_in;
      pl_branch_out <= pl_branch_in;
      pl_q          <= pl_out;
      nl_q          <= nl_out;
      if (pl_update_in) begin
        p_r <= pl_in;
        n_r <= nl_in;
      end
      if ((state == IDLE) && init)
        mode_r <= max_mode;
      if (state == INIT)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign um_out      = pl_out;
  assign um_we       = pl_update_out;
  assign um_addr     = pl_addr_out;
  assign cm_out      = nl_out;
  assign nl_addr_out = cm_addr;

endmodule

// File: tb/tb_heap_sort_node_kary.sv
// Bench for heap_sort_node_kary (FANOUT=4, LEVEL=2): directed steps plus
// randomized swaps checked against a rank-score reference model.
module tb_heap_sort_node_kary;

  logic         clk = 1'b0;
  logic         rstn;
  logic         init;
  logic         max_mode;
  logic         busy;
  logic [31:0]  um_out;
  logic [7:0]   um_addr;
  logic         um_we;
  logic [127:0] cm_in;
  logic [31:0]  cm_out;
  logic [7:0]   cm_addr;
  logic [3:0]   cm_we;
  logic         pl_update_in;
  logic [7:0]   pl_addr_in;
  logic [1:0]   pl_branch_in;
  logic [31:0]  pl_in;
  logic [31:0]  pl_out;
  logic         pl_update_out;
  logic [7:0]   pl_addr_out;
  logic [1:0]   pl_branch_out;
  logic         nl_update_in;
  logic [7:0]   nl_addr_in;
  logic [1:0]   nl_branch_in;
  logic [31:0]  nl_in;
  logic [31:0]  nl_out;
  logic         nl_update_out;
  logic [7:0]   nl_addr_out;
  logic [1:0]   nl_branch_out;

  int tests = 0;
  int fails = 0;

  heap_sort_node_kary #(
    .DATA_WIDTH(32), .KEY_WIDTH(16), .ADDR_WIDTH(8),
    .FANOUT(4), .LEVEL(2)
  ) dut (
    .clk(clk), .rstn(rstn), .init(init), .max_mode(max_mode),
    .busy(busy), .um_out(um_out), .um_addr(um_addr), .um_we(um_we),
    .cm_in(cm_in), .cm_out(cm_out), .cm_addr(cm_addr), .cm_we(cm_we),
    .pl_update_in(pl_update_in), .pl_addr_in(pl_addr_in),
    .pl_branch_in(pl_branch_in), .pl_in(pl_in),
    .pl_out(pl_out), .pl_update_out(pl_update_out),
    .pl_addr_out(pl_addr_out), .pl_branch_out(pl_branch_out),
    .nl_update_in(nl_update_in), .nl_addr_in(nl_addr_in),
    .nl_branch_in(nl_branch_in), .nl_in(nl_in),
    .nl_out(nl_out), .nl_update_out(nl_update_out),
    .nl_addr_out(nl_addr_out), .nl_branch_out(nl_branch_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] W(input int k);
    return {16'h0000, 16'(k)};
  endfunction

  function automatic logic [127:0] pack(input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // lower score = higher priority; sentinels of one type tie
  function automatic int score(input logic [31:0] v, input bit mx);
    int key;
    key = int'(v[15:0]);
    if (!mx) begin
      if (v[31:30] == 2'b01)      return 0;
      else if (v[31:30] == 2'b11) return 3 * 65536;
      else                        return 65536 + key;
    end else begin
      if (v[31:30] == 2'b11)      return 0;
      else if (v[31:30] == 2'b01) return 3 * 65536;
      else                        return 65536 + (65535 - key);
    end
  endfunction

  function automatic logic [31:0] rnd_word();
    int r;
    logic [1:0] f;
    r = $urandom_range(0, 9);
    f = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r == 2) ? 2'b10 : 2'b00;
    return {f, 14'($urandom), 16'($urandom_range(0, 15))};
  endfunction

  task automatic do_init(input bit mx);
    logic [31:0] s;
    s = mx ? 32'hC000_0000 : 32'h4000_0000;
    max_mode = mx;
    init = 1'b1;
    step();
    init = 1'b0;
    max_mode = ~mx;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_we", 32'(cm_we), 32'hf);
      chk("init_addr", 32'(cm_addr), 32'(k));
      chk("init_data", cm_out, s);
      chk("init_upd", {30'd0, pl_update_out, nl_update_out}, 32'd1);
      step();
    end
    #1;
    chk("init_done_busy", 32'(busy), 32'd0);
    chk("init_done_we", 32'(cm_we), 32'd0);
  endtask

  task automatic request(input logic [7:0] a, input logic [1:0] b,
                         input logic [31:0] p, input logic [31:0] n);
    pl_update_in = 1'b1;
    pl_addr_in   = a;
    pl_branch_in = b;
    pl_in        = p;
    nl_in        = n;
    nl_update_in = 1'b0;
    step();
    pl_update_in = 1'b0;
    pl_addr_in   = '0;
    pl_branch_in = '0;
    pl_in        = '0;
  endtask

  task automatic run_random(input bit mx, input int n);
    logic [31:0] ch [4];
    logic [31:0] cand [4];
    logic [31:0] cur_p, cur_n, exp_pl, exp_nl;
    logic [7:0]  cur_ca;
    bit have, hold_ok, newreq, sw;
    int wi;
    have = 0;
    hold_ok = 0;
    cur_p = '0;
    cur_n = '0;
    cur_ca = '0;
    exp_pl = '0;
    exp_nl = '0;
    for (int it = 0; it < n; it++) begin
      newreq = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) ch[k] = rnd_word();
      cm_in        = pack(ch[0], ch[1], ch[2], ch[3]);
      nl_update_in = 1'($urandom_range(0, 1));
      nl_branch_in = 2'($urandom_range(0, 3));
      nl_addr_in   = $urandom_range(0, 1) ? cur_ca : 8'($urandom);
      nl_in        = rnd_word();
      pl_update_in = newreq;
      pl_addr_in   = 8'($urandom_range(0, 63));
      pl_branch_in = 2'($urandom_range(0, 3));
      pl_in        = rnd_word();
      #1;
      if (have) begin
        for (int k = 0; k < 4; k++) cand[k] = ch[k];
        if (nl_update_in && nl_addr_in == cur_ca)
          cand[nl_branch_in] = nl_in;
        wi = 0;
        for (int k = 1; k < 4; k++)
          if (score(cand[k], mx) < score(cand[wi], mx)) wi = k;
        sw = score(cand[wi], mx) < score(cur_p, mx);
        exp_pl = sw ? cand[wi] : cur_p;
        exp_nl = sw ? cur_p : cur_n;
        chk("rnd_pl_out", pl_out, exp_pl);
        chk("rnd_nl_out", nl_out, exp_nl);
        chk("rnd_um_out", um_out, exp_pl);
        chk("rnd_pl_upd", 32'(pl_update_out), 32'(sw));
        chk("rnd_cm_we", 32'(cm_we), sw ? (32'd1 << wi) : 32'd0);
        chk("rnd_branch", 32'(nl_branch_out), sw ? 32'(wi) : 32'd0);
        chk("rnd_cm_addr", 32'(cm_addr), 32'(cur_ca));
        chk("rnd_nl_upd", 32'(nl_update_out), 32'd1);
        hold_ok = 1;
      end else begin
        chk("idle_upd", {30'd0, pl_update_out, nl_update_out}, 32'd0);
        chk("idle_we", 32'(cm_we), 32'd0);
        chk("idle_addr", 32'(cm_addr),
            (32'(pl_addr_in) * 4 + 32'(pl_branch_in)) & 32'hff);
        if (hold_ok) begin
          chk("idle_hold_pl", pl_out, exp_pl);
          chk("idle_hold_nl", nl_out, exp_nl);
        end
      end
      if (newreq) begin
        cur_p  = pl_in;
        cur_n  = nl_in;
        cur_ca = 8'((32'(pl_addr_in) * 4 + 32'(pl_branch_in)) & 32'hff);
      end
      have = newreq;
      step();
    end
    pl_update_in = 1'b0;
    nl_update_in = 1'b0;
    step();
    step();
  endtask

  initial begin
    rstn = 1'b0;
    init = 1'b0;
    max_mode = 1'b0;
    cm_in = '0;
    pl_update_in = 1'b0;
    pl_addr_in = '0;
    pl_branch_in = '0;
    pl_in = '0;
    nl_update_in = 1'b0;
    nl_addr_in = '0;
    nl_branch_in = '0;
    nl_in = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(cm_we), 32'd0);
    chk("rst_pl_out", pl_out, 32'd0);
    chk("rst_nl_out", nl_out, 32'd0);
    chk("rst_um_addr", 32'(um_addr), 32'd0);
    rstn = 1'b1;
    step();

    do_init(1'b0);

    // reset in the middle of a fill
    init = 1'b1;
    step();
    init = 1'b0;
    repeat (5) step();
    chk("mid_addr", 32'(cm_addr), 32'd5);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(cm_we), 32'd0);
    chk("mid_rst_addr", 32'(cm_addr), 32'd0);
    chk("mid_rst_out", cm_out, 32'd0);
    chk("mid_rst_upd", 32'(nl_update_out), 32'd0);
    step();
    rstn = 1'b1;
    step();
    do_init(1'b0);

    // min swap with tie
    request(8'd0, 2'd0, W(50), W(77));
    cm_in = pack(W(40), W(30), W(30), W(60));
    #1;
    chk("min_pl_out", pl_out, W(30));
    chk("min_nl_out", nl_out, W(50));
    chk("min_we", 32'(cm_we), 32'h2);
    chk("min_branch", 32'(nl_branch_out), 32'd1);
    chk("min_upd", 32'(um_we), 32'd1);
    step();

    // no swap
    request(8'd1, 2'd1, W(10), 32'h0000_0777);
    cm_in = pack(W(20), W(30), W(40), W(50));
    #1;
    chk("ns_upd", 32'(pl_update_out), 32'd0);
    chk("ns_we", 32'(cm_we), 32'd0);
    chk("ns_nl_out", nl_out, 32'h0000_0777);
    chk("ns_pl_out", pl_out, W(10));
    step();

    // bypass from level below
    request(8'd3, 2'd2, W(20), W(1));
    nl_update_in = 1'b1;
    nl_addr_in   = 8'd14;
    nl_branch_in = 2'd3;
    nl_in        = W(5);
    cm_in = pack(W(60), W(70), W(80), W(99));
    #1;
    chk("byp_addr", 32'(nl_addr_out), 32'd14);
    chk("byp_pl_out", pl_out, W(5));
    chk("byp_we", 32'(cm_we), 32'h8);
    chk("byp_nl_out", nl_out, W(20));
    step();
    nl_update_in = 1'b0;
    step();

    run_random(1'b0, 60);

    do_init(1'b1);

    // max mode, back-to-back
    pl_update_in = 1'b1;
    pl_addr_in   = 8'd1;
    pl_branch_in = 2'd0;
    pl_in        = W(10);
    nl_in        = W(17);
    step();
    pl_addr_in   = 8'd2;
    pl_branch_in = 2'd1;
    pl_in        = W(70);
    nl_in        = W(34);
    cm_in = pack(W(80), W(20), W(90), W(5));
    #1;
    chk("b2b1_pl_out", pl_out, W(90));
    chk("b2b1_we", 32'(cm_we), 32'h4);
    chk("b2b1_nl_out", nl_out, W(10));
    chk("b2b1_um_addr", 32'(um_addr), 32'd1);
    step();
    pl_update_in = 1'b0;
    cm_in = pack(W(60), W(20), W(70), W(5));
    #1;
    chk("b2b2_upd", {30'd0, pl_update_out, nl_update_out}, 32'd1);
    chk("b2b2_pl_out", pl_out, W(70));
    chk("b2b2_nl_out", nl_out, W(34));
    chk("b2b2_addr", 32'(cm_addr), 32'd9);
    chk("b2b2_um_addr", 32'(um_addr), 32'd2);
    step();
    step();

    run_random(1'b1, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
